fifo_rd_drain: RTL and testbench
================================

Name: fifo_rd_drain

Overview:
- Read-side consumer for the team's FIFO. Runs in the FIFO read clock domain.
- Issues r_en against the FIFO's empty flag and captures the registered FIFO read data one cycle after each accepted read.
- Presents the captured words on a valid/ready output stream through a 2-entry output buffer.
- Sustains 1 word/cycle when the FIFO holds data and the sink is ready. Counts delivered words and supports a synchronous flush.

Parameters:
- f_width, 8, data word width; must match the FIFO width.
- cnt_width, 16, width of the delivered-word counter.

Ports:
- r_clk  input  1  read-domain clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- f_empty_flag  input  1  FIFO empty status; sampled combinationally.
- fifo_d  input  f_width  FIFO registered read data; valid in the cycle after an accepted r_en.
- r_en  output  1  FIFO read enable; combinational.
- m_data  output  f_width  output stream data, equal to the buffer head.
- m_valid  output  1  output stream valid.
- m_ready  input  1  output stream ready from the sink.
- flush  input  1  synchronous discard of the buffer and any in-flight word.
- rd_count  output  cnt_width  number of words delivered (m_valid && m_ready); wraps modulo 2^cnt_width.
- rd_busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: occ=0, inflight=0, buffer entries=0, rd_count=0, state=IDLE, m_valid=0, m_data=0, r_en=0.
- Reset has priority over flush and over all other inputs.
- pop = m_valid && m_ready.
- r_en = !f_empty_flag && !flush && !reset && ((occ + inflight - pop) < 2).
  - Evaluate with a 3-bit unsigned sum; occ is 0..2 and inflight is 0..1.
  - This term stops the buffer from overflowing.
- inflight is registered as r_en: a read issued in cycle t means fifo_d holds that word in cycle t+1.
- If inflight=1, write fifo_d into the buffer tail at the end of the cycle.
- Latency: r_en in cycle t, word captured at the end of t+1, m_valid=1 in cycle t+2.
- Buffer is a 2-entry FIFO, registered head/tail, ordered.
  - m_data = head entry; m_valid = (occ != 0).
  - A push and a pop in the same cycle leave occ unchanged and preserve order.
  - With occ=0, a push and no pop sets occ=1.
  - A pop with no push shifts entry1 to entry0.
- m_data holds stable while m_valid=1 and m_ready=0. m_data is don't-care when m_valid=0, but the block must drive a deterministic value.
- rd_count increments by 1 on each pop and wraps from 2^cnt_width-1 to 0.
- State machine (registered, updated from the next-cycle occ/inflight):
  - IDLE: occ=0 and inflight=0.
  - ACTIVE: occ=1, or inflight=1 with occ<2.
  - FULL: occ=2. In FULL, r_en is asserted only in a cycle with pop=1.
- Flush (synchronous, one cycle):
  - r_en=0 in that cycle.
  - At the end of the cycle: occ=0, inflight=0, state=IDLE.
  - Any word returning on fifo_d in the flush cycle is dropped.
  - A pop in the flush cycle still counts in rd_count.
  - rd_count is not cleared by flush.
- FIFO empty: r_en stays 0. An in-flight word still completes. m_valid stays high while occ>0.
- Sink stall: the buffer fills to 2 and r_en drops. With m_ready=0 there is no loss and no duplication.
- The block never drives r_en while f_empty_flag=1, so the FIFO read pointer never moves on an empty FIFO.
- Reset mid-transfer: the in-flight word is discarded. The FIFO is assumed to be reset by the same reset.

Test Plan:
- Reset: hold reset 3 cycles with f_empty_flag=0 and m_ready=1 -> r_en=0, m_valid=0, rd_count=0, rd_busy=0 throughout.
- Streaming: FIFO holds 0x11..0x18 (8 words), m_ready=1 -> r_en high from cycle 0; m_valid first high in cycle 2; m_data 0x11..0x18 on consecutive cycles; rd_count=8; r_en never high while empty.
- Backpressure: 5 words queued, m_ready=0 for 10 cycles then 1 -> exactly 2 r_en pulses during the stall; occ=2, state FULL, m_data=first word and stable; after release all 5 words out in order; rd_count=5.
- Alternating ready: m_ready toggles 1/0 with 6 words queued -> 6 words delivered in order, no duplicates; occ never exceeds 2.
- Flush: flush in the cycle after r_en with occ=1 -> the in-flight word and the buffered word are both dropped; m_valid=0 next cycle; rd_count unchanged; later words are delivered in order.
- Wrap: cnt_width=4, 18 words delivered -> rd_count wraps through 15 -> 0 and ends at 2.

Source files
------------

// File: rtl/fifo_rd_drain_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_drain_if
// Bundles the two handshakes of the FIFO read-side drain:
//   FIFO side  : f_empty_flag, fifo_d (into the drain), r_en (out of the drain)
//   Stream side: m_data, m_valid (out of the drain), m_ready (into the drain)
// Stream handshake: a word moves on every rising edge where m_valid && m_ready.
// m_valid never depends on m_ready, and m_data holds while m_valid && !m_ready.
// Modports:
//   master : the drain block itself
//   slave  : the FIFO plus the downstream sink
// ---------------------------------------------------------------------------
interface fifo_rd_drain_if #(
    parameter int f_width = 8
);
    logic               f_empty_flag;
    logic [f_width-1:0] fifo_d;
    logic               r_en;
    logic [f_width-1:0] m_data;
    logic               m_valid;
    logic               m_ready;

    modport master (
        input  f_empty_flag,
        input  fifo_d,
        output r_en,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        output f_empty_flag,
        output fifo_d,
        input  r_en,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// ---------------------------------------------------------------------------
// fifo_rd_drain
// Read-side consumer for the FIFO. Issues r_en against the empty flag,
// captures the registered FIFO data one cycle after each accepted read, and
// presents the words on a valid/ready stream through a 2-entry buffer.
// Sustains one word per cycle, counts delivered words, supports flush.
// Ports:
//   r_clk      read-domain clock (rising edge)
//   reset      synchronous active-high reset, overrides everything
//   flush      one-cycle synchronous discard of buffer and in-flight word
//   bus        fifo_rd_drain_if.master (FIFO read port + output stream)
//   rd_count   delivered-word count, wraps modulo 2^cnt_width
//   rd_busy    high whenever the state is not IDLE
//   dbg_state  current state: 0 = IDLE, 1 = ACTIVE, 2 = FULL
// ---------------------------------------------------------------------------
module fifo_rd_drain #(
    parameter int f_width   = 8,
    parameter int cnt_width = 16
) (
    input  logic                 r_clk,
    input  logic                 reset,
    input  logic                 flush,
    fifo_rd_drain_if.master      bus,
    output logic [cnt_width-1:0] rd_count,
    output logic                 rd_busy,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q;
    logic [f_width-1:0]   buf0_q, buf0_d;
    logic [f_width-1:0]   buf1_q, buf1_d;
    logic [cnt_width-1:0] count_q, count_d;

    logic                 pop;
    logic                 push;
    logic                 r_en_c;
    logic [2:0]           pending;

    always_comb begin
        pop  = (occ_q != 2'd0) && bus.m_ready;
        // A word returning during flush is dropped, never written.
        push = inflight_q && !flush;
        // Slots already claimed once this cycle's pop leaves; pop implies
        // occ_q >= 1, so the subtraction cannot underflow.
        pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        r_en_c  = !bus.f_empty_flag && !flush && !reset && (pending < 3'd2);

        occ_d   = occ_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q + {{(cnt_width-1){1'b0}}, pop};

        if (flush) begin
            occ_d  = 2'd0;
            buf0_d = '0;
            buf1_d = '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // Occupancy unchanged; new word lands behind the survivor.
                    if (occ_q == 2'd1) begin
                        buf0_d = bus.fifo_d;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = bus.fifo_d;
                    end
                end
                2'b10: begin
                    if (occ_q == 2'd0) buf0_d = bus.fifo_d;
                    else               buf1_d = bus.fifo_d;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    occ_d  = occ_q - 2'd1;
                end
                default: begin
                end
            endcase
        end

        // State tracks the occupancy/in-flight values that hold next cycle.
        if (occ_d == 2'd2)                 state_d = ST_FULL;
        else if (occ_d != 2'd0 || r_en_c)  state_d = ST_ACTIVE;
        else                               state_d = ST_IDLE;
    end

    always_ff @(posedge r_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= r_en_c;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
        end
    end

    assign bus.r_en    = r_en_c;
    assign bus.m_data  = buf0_q;
    assign bus.m_valid = (occ_q != 2'd0);
    assign rd_count    = count_q;
    assign rd_busy     = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;
  localparam int FW = 8;
  localparam int CW = 4;

  // clock / reset
  logic r_clk = 1'b0;
  logic reset;
  logic flush;
  always #5 r_clk = ~r_clk;

  logic [CW-1:0] rd_count;
  logic          rd_busy;
  logic [1:0]    dbg_state;

  fifo_rd_drain_if #(.f_width(FW)) bus ();

  fifo_rd_drain #(.f_width(FW), .cnt_width(CW)) dut (
    .r_clk     (r_clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .rd_count  (rd_count),
    .rd_busy   (rd_busy),
    .dbg_state (dbg_state)
  );

  // FIFO contents not yet read, and words read but not yet delivered
  logic [FW-1:0] mem_q[$];
  logic [FW-1:0] exp_q[$];
  int            avail_q[$];   // first cycle each read word may be presented

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  int dlv_cnt  = 0;
  logic          obs_ren;
  logic          obs_valid;
  logic          last_stall = 1'b0;
  logic [FW-1:0] last_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load(input int n, input logic [FW-1:0] base);
    for (int i = 0; i < n; i++) mem_q.push_back(base + FW'(i));
    bus.f_empty_flag = (mem_q.size() == 0);
  endtask

  // One clock cycle: observe at negedge against the model, then advance
  // the FIFO model at the rising edge.
  task automatic tick();
    int   occ;
    logic exp_valid;
    logic exp_ren;
    logic pop;
    logic [1:0] exp_st;
    @(negedge r_clk);
    obs_ren   = bus.r_en;
    obs_valid = bus.m_valid;
    if (bus.r_en) check("ren_while_empty", bus.f_empty_flag, 1'b0);
    if (reset) begin
      check("rst_ren", bus.r_en, 1'b0);
    end else begin
      occ = 0;
      foreach (avail_q[i]) if (avail_q[i] <= cyc) occ++;
      exp_valid = (occ != 0);
      exp_st = (occ == 2) ? 2'd2 : ((exp_q.size() != 0) ? 2'd1 : 2'd0);
      check("m_valid", bus.m_valid, exp_valid);
      check("state", dbg_state, exp_st);
      check("rd_busy", rd_busy, exp_st != 2'd0);
      check("rd_count", rd_count, dlv_cnt & ((1 << CW) - 1));
      if (last_stall && bus.m_valid) check("m_data_hold", bus.m_data, last_data);
      pop = exp_valid && bus.m_ready;
      if (pop) begin
        check("m_data", bus.m_data, exp_q[0]);
        void'(exp_q.pop_front());
        void'(avail_q.pop_front());
        dlv_cnt++;
      end
      exp_ren = (mem_q.size() != 0) && !flush && (exp_q.size() < 2);
      check("r_en", bus.r_en, exp_ren);
      if (flush) begin
        exp_q.delete();
        avail_q.delete();
      end
      if (exp_ren) begin
        exp_q.push_back(mem_q[0]);
        avail_q.push_back(cyc + 2);
      end
      last_stall = bus.m_valid && !bus.m_ready;
      last_data  = bus.m_data;
    end
    @(posedge r_clk);
    #1;
    cyc++;
    if (reset) begin
      exp_q.delete();
      avail_q.delete();
      dlv_cnt    = 0;
      last_stall = 1'b0;
    end
    if (obs_ren && mem_q.size() != 0) bus.fifo_d = mem_q.pop_front();
    bus.f_empty_flag = (mem_q.size() == 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    i = 0;
    while (i < budget && !(mem_q.size() == 0 && exp_q.size() == 0)) begin
      tick();
      i++;
    end
    check(tag, (mem_q.size() == 0 && exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    int start_cyc;
    int first_ren;
    int first_val;
    int d0;
    int pulses;
    logic [CW-1:0] cnt_before;

    reset = 1'b1;
    flush = 1'b0;
    bus.m_ready = 1'b1;
    bus.fifo_d  = '0;
    load(2, 8'h55);

    // Reset held 3 cycles with data available and sink ready
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_rd_count", rd_count, '0);
      check("rst_rd_busy", rd_busy, 1'b0);
      check("rst_r_en", bus.r_en, 1'b0);
    end
    mem_q.delete();
    bus.f_empty_flag = 1'b1;
    reset = 1'b0;

    // Streaming 0x11..0x18
    load(8, 8'h11);
    start_cyc = cyc;
    first_ren = -1;
    first_val = -1;
    d0 = dlv_cnt;
    for (int i = 0; i < 40 && !(mem_q.size() == 0 && exp_q.size() == 0); i++) begin
      int c;
      c = cyc;
      tick();
      if (obs_ren && first_ren < 0) first_ren = c;
      if (obs_valid && first_val < 0) first_val = c;
    end
    check("stream_first_ren", first_ren, start_cyc);
    check("stream_latency", first_val - first_ren, 2);
    check("stream_count", dlv_cnt - d0, 8);
    check("stream_rd_count", rd_count, 4'd8);

    // Backpressure: 5 words, sink stalled 10 cycles
    bus.m_ready = 1'b0;
    load(5, 8'h21);
    d0 = dlv_cnt;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_ren) pulses++;
    end
    check("bp_ren_pulses", pulses, 2);
    check("bp_state_full", dbg_state, 2'd2);
    check("bp_head", bus.m_data, 8'h21);
    bus.m_ready = 1'b1;
    drain("bp_drain", 40);
    check("bp_count", dlv_cnt - d0, 5);
    check("bp_rd_count", rd_count, 4'd13);

    // Alternating ready, 6 words
    load(6, 8'h31);
    d0 = dlv_cnt;
    for (int i = 0; i < 60 && !(mem_q.size() == 0 && exp_q.size() == 0); i++) begin
      bus.m_ready = (i % 2 == 0);
      tick();
    end
    check("alt_drained", (mem_q.size() == 0 && exp_q.size() == 0), 1'b1);
    check("alt_count", dlv_cnt - d0, 6);

    // Flush with one word buffered and one in flight
    bus.m_ready = 1'b0;
    load(1, 8'hA0);
    tick();
    tick();
    tick();
    check("fl_occ1_valid", bus.m_valid, 1'b1);
    load(4, 8'hA1);
    tick();
    cnt_before = rd_count;
    d0 = dlv_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid_after", bus.m_valid, 1'b0);
    check("fl_rd_count_kept", rd_count, cnt_before);
    bus.m_ready = 1'b1;
    drain("fl_drain", 40);
    check("fl_count_after", dlv_cnt - d0, 3);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if (mem_q.size() < 4 && $urandom_range(0, 2) == 0) load(1, FW'($urandom_range(0, 255)));
      tick();
    end
    flush = 1'b0;
    bus.m_ready = 1'b1;
    drain("rnd_drain", 60);

    // Reset in the middle of a transfer
    load(4, 8'hC0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_q.delete();
    bus.f_empty_flag = 1'b1;
    check("midrst_valid", bus.m_valid, 1'b0);
    check("midrst_count", rd_count, '0);
    tick();
    tick();
    check("midrst_no_word", bus.m_valid, 1'b0);

    // Counter wrap: 18 words from zero
    load(18, 8'h40);
    d0 = dlv_cnt;
    drain("wrap_drain", 80);
    check("wrap_count", dlv_cnt - d0, 18);
    check("wrap_rd_count", rd_count, 4'd2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
